// File: rtl/ss_pkg.sv
// Shared types for the seven-segment display path: arbiter state encoding,
// digit count and the native 4-hex-digit display word.
package ss_pkg;

  typedef enum logic {
    IDLE,
    HOLD
  } ss_arb_state_e;

  localparam int SS_DIGITS = 4;

  typedef logic [15:0] ss_word_t;

endpackage

// File: rtl/ss_rr_picker.sv
// Combinational round-robin scan: returns the first set bit of req at or after
// start, wrapping modulo NUM_REQ.
module ss_rr_picker
  import ss_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int pos;

  // Walk from the farthest offset back to start so the closest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = (int'(start) + i) % NUM_REQ;
      if (req[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/ss_display_arbiter.sv
// Round-robin owner selection for the shared seven-segment display with a minimum
// tenure counted in clk_en_i ticks. Define SS_ARB_PREEMPT_EN to make requester 0 urgent.
module ss_display_arbiter
  import ss_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 16,
  parameter int HOLD_TICKS = 256
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        clk_en_i,
  input  logic [NUM_REQ-1:0]                          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]                   data_i,
  output logic [NUM_REQ-1:0]                          grant_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o,
  output logic                                        valid_o,
  output logic [DATA_W-1:0]                           bin_o
);

  localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HC_W = $clog2(HOLD_TICKS + 1);

  ss_arb_state_e       state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [OW-1:0]       owner_reg, owner_next;
  logic                valid_reg, valid_next;
  logic [DATA_W-1:0]   bin_reg, bin_next;
  logic [HC_W-1:0]     hold_cnt_reg, hold_cnt_next;

  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [OW-1:0]       start_idx;
  logic [NUM_REQ-1:0]  owner_onehot;
  logic [NUM_REQ-1:0]  other_req;
  logic                any_found, other_found;
  logic [OW-1:0]       any_idx, other_idx;
  logic                urgent;
  logic                take;
  logic [OW-1:0]       win;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign start_idx    = (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
  assign owner_onehot = NUM_REQ'(1) << owner_reg;
  assign other_req    = req_i & ~owner_onehot;

  ss_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(OW)) u_pick_any (
    .req   (req_i),
    .start (start_idx),
    .found (any_found),
    .idx   (any_idx)
  );

  ss_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(OW)) u_pick_other (
    .req   (other_req),
    .start (start_idx),
    .found (other_found),
    .idx   (other_idx)
  );

`ifdef SS_ARB_PREEMPT_EN
  assign urgent = req_i[0] && (owner_reg != '0);
`else
  assign urgent = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    valid_next    = valid_reg;
    bin_next      = bin_reg;
    hold_cnt_next = hold_cnt_reg;
    take          = 1'b0;
    win           = '0;

    case (state_reg)
      IDLE: begin
        if (any_found) begin
          take = 1'b1;
          win  = any_idx;
        end
      end
      HOLD: begin
        if (!req_i[owner_reg]) begin
          // Owner bit is clear here, so the unmasked scan already excludes it.
          if (any_found) begin
            take = 1'b1;
            win  = urgent ? '0 : any_idx;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            valid_next = 1'b0;
          end
        end else if (urgent) begin
          take = 1'b1;
          win  = '0;
        end else if (hold_cnt_reg == '0 && other_found) begin
          take = 1'b1;
          win  = other_idx;
        end else begin
          bin_next = data_arr[owner_reg];
          if (clk_en_i && hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Counter loads the full tick count so it reaches zero on the HOLD_TICKS-th tick.
    if (take) begin
      state_next    = HOLD;
      grant_next    = NUM_REQ'(1) << win;
      owner_next    = win;
      valid_next    = 1'b1;
      bin_next      = data_arr[win];
      hold_cnt_next = HC_W'(HOLD_TICKS);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_reg    <= OW'(NUM_REQ - 1);
      valid_reg    <= 1'b0;
      bin_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      valid_reg    <= valid_next;
      bin_reg      <= bin_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign grant_o = grant_reg;
  assign owner_o = owner_reg;
  assign valid_o = valid_reg;
  assign bin_o   = bin_reg;

endmodule
